// File: rtl/gpio_input_conditioner_pkg.sv
// Shared types and defaults for the GPIO input conditioner and its per-bit debouncer.
package gpio_pkg;

  typedef enum logic [0:0] {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_t;

  localparam int GPIO_WIDTH              = 8;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Counter width that still holds DEBOUNCE_CYCLES-1, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/gpio_input_conditioner_if.sv
// Pad-side and datapath-side signals of the GPIO input conditioner.
interface gpio_input_conditioner_if
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
);

  logic [WIDTH-1:0] pad_i;
  logic             clear_i;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             changed_o;

  modport master (
    output pad_i,
    output clear_i,
    input  gpio_o,
    input  rise_o,
    input  fall_o,
    input  changed_o
  );

  modport slave (
    input  pad_i,
    input  clear_i,
    output gpio_o,
    output rise_o,
    output fall_o,
    output changed_o
  );

endinterface

// File: rtl/gpio_input_conditioner_checker.sv
// Output invariants of the GPIO input conditioner, bound in by the top level.
module gpio_input_conditioner_checker #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  input logic [WIDTH-1:0] gpio,
  input logic [WIDTH-1:0] rise,
  input logic [WIDTH-1:0] fall,
  input logic             changed
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  a_rise_fall_exclusive: assert property (@(posedge clk) disable iff (!reset)
    ((rise & fall) == ZERO));

  a_rise_matches_level: assert property (@(posedge clk) disable iff (!reset)
    ((rise & ~gpio) == ZERO));

  a_fall_matches_level: assert property (@(posedge clk) disable iff (!reset)
    ((fall & gpio) == ZERO));

  a_pulse_sets_changed: assert property (@(posedge clk) disable iff (!reset)
    ((|(rise | fall)) |-> changed));

endmodule

// File: rtl/gpio_input_conditioner_debounce.sv
// One GPIO bit: synchroniser chain, STABLE/CHANGING debounce FSM and edge pulses.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall,
  output logic accept
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  deb_state_t             state_r;
  deb_state_t             state_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt_s;
  logic                   level_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   accept_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchroniser shift chain; bit 0 is the first flop after the pad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pad};
    end
  end

  // Debounce next-state: a new level must survive DEBOUNCE_CYCLES samples to be accepted.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      STABLE: begin
        if (s_s != level_r) begin
          state_nxt_s = CHANGING;
          cnt_nxt_s   = CNT_ONE;
        end else begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      CHANGING: begin
        if (s_s == level_r) begin
          state_nxt_s = STABLE;
          cnt_nxt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_MAX) begin
          accept_s    = 1'b1;
          state_nxt_s = STABLE;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = CHANGING;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = STABLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= STABLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Accepted level plus rise/fall pulses, all visible in the cycle after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else if (accept_s) begin
      level_r <= s_s;
      rise_r  <= s_s;
      fall_r  <= ~s_s;
    end else begin
      level_r <= level_r;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end
  end

  assign level  = level_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign accept = accept_s;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: WIDTH independent debounced bits plus the sticky changed flag.
module gpio_input_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH           = GPIO_WIDTH,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic                     clk,
  input logic                     reset,
  gpio_input_conditioner_if.slave gpio_bus
);

  logic [WIDTH-1:0] level_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] accept_s;
  logic             changed_r;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .pad    (gpio_bus.pad_i[i]),
      .level  (level_s[i]),
      .rise   (rise_s[i]),
      .fall   (fall_s[i]),
      .accept (accept_s[i])
    );
  end

  // Sticky change flag: any acceptance sets it and wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      changed_r <= 1'b0;
    end else if (|accept_s) begin
      changed_r <= 1'b1;
    end else if (gpio_bus.clear_i) begin
      changed_r <= 1'b0;
    end else begin
      changed_r <= changed_r;
    end
  end

  assign gpio_bus.gpio_o    = level_s;
  assign gpio_bus.rise_o    = rise_s;
  assign gpio_bus.fall_o    = fall_s;
  assign gpio_bus.changed_o = changed_r;

  gpio_input_conditioner_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clk     (clk),
    .reset   (reset),
    .gpio    (level_s),
    .rise    (rise_s),
    .fall    (fall_s),
    .changed (changed_r)
  );

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed, table-driven bench for gpio_input_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_gpio_input_conditioner;

  typedef struct {
    logic [7:0] pad;
    logic       clr;
    logic [7:0] gpio;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  gpio_input_conditioner_if #(.WIDTH(8)) bus ();

  gpio_input_conditioner #(
    .WIDTH           (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .gpio_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] p, input logic c, input logic [7:0] g,
                              input logic [7:0] r, input logic [7:0] f, input logic ch);
    vec_t v;
    v.pad = p; v.clr = c; v.gpio = g; v.rise = r; v.fall = f; v.chg = ch;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, "/gpio"},    bus.gpio_o, v.gpio);
    check({tag, "/rise"},    bus.rise_o, v.rise);
    check({tag, "/fall"},    bus.fall_o, v.fall);
    check({tag, "/changed"}, {7'b0, bus.changed_o}, {7'b0, v.chg});
  endtask

  // Drive one cycle of inputs, then check outputs just after the following rising edge.
  task automatic apply_row(input vec_t v, input string tag);
    bus.pad_i   = v.pad;
    bus.clear_i = v.clr;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected end well before", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held low with all pads high: everything stays at zero.
    reset       = 1'b0;
    bus.pad_i   = 8'hFF;
    bus.clear_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_outs($sformatf("reset%0d", i), mk(8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    end
    bus.pad_i = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) apply_row(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0), "idle");

    // Clean rise of bit 0: visible exactly 6 edges after the change.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h01, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(8'h01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1));
    // Fall of bit 0 with clear on the accepting cycle: set wins.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 8'h00, 8'h01, 1'b1));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1));
    // Clear on an idle cycle.
    tbl.push_back(mk(8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    // Bit 3 glitch of 3 cycles is rejected.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h08, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    // Bit 2 pulse of exactly 4 cycles is accepted, then its return to 0 as well.
    for (int i = 0; i < 4; i++) tbl.push_back(mk(8'h04, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(8'h00, 1'b0, 8'h04, 8'h04, 8'h00, 1'b1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h04, 8'h00, 8'h00, 1'b1));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'h04, 1'b1));
    tbl.push_back(mk(8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1));

    foreach (tbl[i]) apply_row(tbl[i], $sformatf("row%0d", i));

    // Reset in the middle of a debounce (bit 0 in CHANGING, cnt=2).
    for (int i = 0; i < 4; i++) apply_row(mk(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1), "pre_rst");
    reset = 1'b0;
    #1;
    check_outs("rst_async", mk(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_outs("rst_hold", mk(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0));
    end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) apply_row(mk(8'h01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0), "post_rst");
    apply_row(mk(8'h01, 1'b0, 8'h01, 8'h01, 8'h00, 1'b1), "post_rst_acc");
    apply_row(mk(8'h01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1), "post_rst_hold");

    // Move to gpio_o=0x80: bit 7 rises while bit 0 falls in the same cycle.
    for (int i = 0; i < 5; i++) apply_row(mk(8'h80, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1), "to80");
    apply_row(mk(8'h80, 1'b0, 8'h80, 8'h80, 8'h01, 1'b1), "to80_acc");

    // Independent bits: 0x80 -> 0x02, then 0x03 two cycles later.
    for (int i = 0; i < 2; i++) apply_row(mk(8'h02, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1), "ind");
    for (int i = 0; i < 3; i++) apply_row(mk(8'h03, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1), "ind");
    apply_row(mk(8'h03, 1'b0, 8'h02, 8'h02, 8'h80, 1'b1), "ind_acc1");
    apply_row(mk(8'h03, 1'b1, 8'h02, 8'h00, 8'h00, 1'b0), "ind_clr");
    apply_row(mk(8'h03, 1'b0, 8'h03, 8'h01, 8'h00, 1'b1), "ind_acc0");
    apply_row(mk(8'h03, 1'b0, 8'h03, 8'h00, 8'h00, 1'b1), "ind_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_input_conditioner.md
# gpio_input_conditioner

- Conditions the raw external input pads before they reach the datapath's 8-bit `GPIO_i` port.
- Per bit, it synchronises the pad into `clk`, rejects glitches shorter than a programmable number of cycles, and presents a stable value.
- Alongside the value it produces one-cycle rise/fall pulses and a sticky "input changed" flag that software-visible logic can clear.
- It sits directly upstream of the datapath: `gpio_o` drives `GPIO_i`.

## Interface
Parameters:
- `WIDTH`, 8, number of GPIO input bits.
- `SYNC_STAGES`, 2, synchroniser flop depth; legal values ≥2.
- `DEBOUNCE_CYCLES`, 50000, cycles a new level must persist before acceptance; legal values ≥2.

Ports:
- `clk`  in  1  single system clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pad_i`  in  WIDTH  raw asynchronous pad levels.
- `clear_i`  in  1  clears `changed_o`; level-sampled each cycle.
- `gpio_o`  out  WIDTH  debounced, stable input value; feeds datapath `GPIO_i`.
- `rise_o`  out  WIDTH  per-bit one-cycle pulse, accepted 0→1.
- `fall_o`  out  WIDTH  per-bit one-cycle pulse, accepted 1→0.
- `changed_o`  out  1  sticky; set when any `gpio_o` bit changes.

## Operation
- Synchroniser: `pad_i[i]` passes through `SYNC_STAGES` flops; the last stage is `s[i]`.
- Per-bit FSM, each bit with its own counter `cnt` of width $clog2(DEBOUNCE_CYCLES):
  - **STABLE**
    - `s[i] == gpio_o[i]`: stay; `cnt` = 0.
    - `s[i] != gpio_o[i]`: go to CHANGING; `cnt` = 1.
  - **CHANGING**
    - `s[i] == gpio_o[i]`: glitch rejected; go to STABLE; `cnt` = 0; no output change.
    - Else, `cnt == DEBOUNCE_CYCLES-1`: `gpio_o[i]` <= `s[i]`; go to STABLE; `cnt` = 0; assert `rise_o[i]` or `fall_o[i]` per direction.
    - Else: `cnt` += 1.
- Counter never wraps: the accept branch is taken exactly at `DEBOUNCE_CYCLES-1`.
- `rise_o`/`fall_o`:
  - Registered; high only in the cycle immediately after the accepting edge, i.e. the first cycle the new `gpio_o` is visible.
  - Deassert the following cycle.
- `changed_o`:
  - Set at any edge where any bit is accepted.
  - Otherwise cleared at an edge where `clear_i` = 1.
  - Set has priority over clear in the same cycle.
- Bits are fully independent; several bits may accept in the same cycle. `changed_o` is then set once.
- Reset (asserted, any state, including mid-CHANGING):
  - All synchroniser flops, `cnt`, `gpio_o`, `rise_o`, `fall_o` and `changed_o` go to 0; all FSMs go to STABLE.
  - A pad held high through reset release is reported as a normal rise after full latency, setting `changed_o`.

## Timing
- Latency: a pad level change sampled at edge 1 appears on `gpio_o` at edge `SYNC_STAGES + DEBOUNCE_CYCLES`, provided it is held throughout.
- Minimum accepted pulse width: `DEBOUNCE_CYCLES` cycles of `s`. Any shorter excursion produces no output activity.
- `clear_i` acts at the next edge; no handshake beyond priority to set.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `gpio_pkg`:
  - `deb_state_t` enum {STABLE, CHANGING}.
  - `GPIO_WIDTH` = 8.
  - Default `DEBOUNCE_CYCLES` constant.
- Sub-module `gpio_debounce_bit`:
  - One synchroniser chain, FSM and counter.
  - Outputs: `level`, `rise`, `fall`.
  - Instantiated `WIDTH` times by generate.
- Top level holds the `changed_o` register and OR-reduction of the accept strobes.

## Test plan
Bench parameters `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4.
- Reset: assert `reset`=0 with `pad_i`=0xFF → `gpio_o`=0x00, `rise_o`=`fall_o`=0x00, `changed_o`=0 throughout.
- Clean rise: `pad_i` 0x00→0x01 held → `gpio_o`=0x01 exactly 6 edges later; `rise_o`=0x01 for that one cycle only; `changed_o`=1 and stays 1.
- Glitch rejection: bit 3 high for 3 cycles, then low → `gpio_o` stays 0x00, no pulses, `changed_o` unchanged.
- Clear vs. set: `clear_i`=1 on the same cycle a bit is accepted → `changed_o` remains 1. `clear_i`=1 on a later idle cycle → `changed_o`=0 next cycle.
- Reset mid-debounce: bit 0 in CHANGING with `cnt`=2, pulse `reset` low → all outputs 0. After release with the pad still high, acceptance occurs 6 edges later.
- Independent bits, `gpio_o`=0x80:
  - `pad_i` 0x80→0x02, then 0x02→0x03 two cycles later.
  - Required response: `fall_o`=0x80 with `rise_o`=0x02 in the same cycle; `rise_o`=0x01 two cycles after that; final `gpio_o`=0x03.
